// File: rtl/lmsm_pkg.sv
// Shared types and constants for the LM/SM multi-cycle sequencer.
package lmsm_pkg;

  localparam int unsigned NREG_DEF      = 8;
  localparam int unsigned ADDR_STEP_DEF = 1;
  localparam int unsigned IDX_W         = 3;
  localparam int unsigned ADDR_W        = 16;
  localparam int unsigned DATA_W        = 16;

  // List bit p names register (BIT_TO_REG_TOP - p): bit 7 is R0, bit 0 is R7.
  localparam logic [IDX_W-1:0] BIT_TO_REG_TOP = IDX_W'(NREG_DEF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Map a list bit position to its architectural register index.
  function automatic logic [IDX_W-1:0] reg_of_bit(input logic [IDX_W-1:0] bit_pos);
    return BIT_TO_REG_TOP - bit_pos;
  endfunction

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Instruction-issue, memory and register-file signals of the LM/SM sequencer.
interface lmsm_sequencer_if;
  import lmsm_pkg::*;

  logic                start;
  logic                is_lm;
  logic [ADDR_W-1:0]   base_addr;
  logic [NREG_DEF-1:0] reg_list;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_ack;

  logic [IDX_W-1:0]    rf_raddr;
  logic [DATA_W-1:0]   rf_rdata;
  logic                rf_we;
  logic [IDX_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  logic                busy;
  logic                done;

  // Sequencer side.
  modport master (
    input  start, is_lm, base_addr, reg_list, mem_rdata, mem_ack, rf_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr,
           rf_wdata, busy, done
  );

  // Pipeline / memory / register-file side.
  modport slave (
    output start, is_lm, base_addr, reg_list, mem_rdata, mem_ack, rf_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, rf_raddr, rf_we, rf_waddr,
           rf_wdata, busy, done
  );

endinterface

// File: rtl/lmsm_pick.sv
// Priority pick of the next register from an LM/SM list (highest set bit first).
module lmsm_pick
  import lmsm_pkg::*;
(
  input  logic [NREG_DEF-1:0] list,
  output logic [IDX_W-1:0]    idx,
  output logic [NREG_DEF-1:0] remaining,
  output logic                empty
);

  logic [IDX_W-1:0] pos;

  // Scan upward so the highest set bit is the one left standing.
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < NREG_DEF; i++) begin
      if (list[i]) pos = IDX_W'(i);
    end
  end

  // Register index of the winner and the list with that bit retired.
  always_comb begin
    idx       = reg_of_bit(pos);
    remaining = list & ~(NREG_DEF'(1) << pos);
    empty     = (list == '0);
  end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM controller: walks the register list, one memory transfer per register.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int unsigned NREG      = NREG_DEF,
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  lmsm_sequencer_if.master bus
);

  state_t            state, state_nxt;
  logic [NREG-1:0]   list_q;
  logic [ADDR_W-1:0] addr_q;
  logic              lm_q;

  logic [IDX_W-1:0]  pick_idx;
  logic [NREG-1:0]   pick_rem;
  logic              pick_empty;

  lmsm_pick u_pick (
    .list      (list_q),
    .idx       (pick_idx),
    .remaining (pick_rem),
    .empty     (pick_empty)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latched instruction operands; list and address advance on each acknowledged transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      list_q <= '0;
      addr_q <= '0;
      lm_q   <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      list_q <= bus.reg_list;
      addr_q <= bus.base_addr;
      lm_q   <= bus.is_lm;
    end else if (state == XFER && bus.mem_ack) begin
      list_q <= pick_rem;
      addr_q <= addr_q + ADDR_W'(ADDR_STEP);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = (bus.reg_list != '0) ? XFER : FIN;
      XFER: if (bus.mem_ack && pick_rem == '0) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore transfer outputs plus the acknowledge-qualified register-file write.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.rf_raddr  = '0;
    bus.rf_waddr  = '0;
    bus.rf_we     = 1'b0;
    bus.rf_wdata  = '0;
    bus.busy      = (state != IDLE);
    bus.done      = 1'b0;
    case (state)
      XFER: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = ~lm_q;
        bus.mem_addr  = addr_q;
        bus.rf_raddr  = pick_idx;
        bus.rf_waddr  = pick_idx;
        bus.mem_wdata = lm_q ? '0 : bus.rf_rdata;
        bus.rf_we     = lm_q & bus.mem_ack & ~pick_empty;
        bus.rf_wdata  = bus.mem_rdata;
      end
      FIN:     bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule
